// File: rtl/scan_mux_if.sv
// Channel bus between the digit sources and the display driver.
// No valid/ready here: every input is sampled on every clock edge, outputs are registered.
interface scan_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        blank;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        y;
  logic [NUM_CH-1:0]        an_n;
  logic [SEL_W-1:0]         ch_idx;
  logic                     tick;

  modport master (
    output data_in, blank, mode, sel,
    input  y, an_n, ch_idx, tick
  );

  modport slave (
    input  data_in, blank, mode, sel,
    output y, an_n, ch_idx, tick
  );
endinterface

// File: rtl/scan_mux_ctrl.sv
// N-channel time-multiplexed selector: auto-scan on a prescaled tick or manual select,
// with per-channel blanking and a dead-time guard on every channel change.
module scan_mux_ctrl #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int DIV    = 100000,
  parameter int GUARD  = 2,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic     clk,
  input  logic     reset,
  scan_mux_if.slave bus
);
  localparam int              PW      = $clog2(DIV);
  localparam int              GW      = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ALL_OFF = '1;

  logic [PW-1:0]     r_pcnt;
  logic              r_tick;
  logic [SEL_W-1:0]  r_ch;
  logic [GW-1:0]     r_guard;
  logic [DATA_W-1:0] r_y;
  logic [NUM_CH-1:0] r_an_n;

  logic [SEL_W-1:0]  w_nidx;
  logic              w_change;
  logic              w_blank;
  logic [DATA_W-1:0] w_ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign w_ch_data[k] = bus.data_in[k*DATA_W +: DATA_W];
  end

  // Manual select clamps out-of-range indices to the last channel.
  always_comb begin
    w_nidx = r_ch;
    if (bus.mode) begin
      if ({1'b0, bus.sel} > {1'b0, LAST}) w_nidx = LAST;
      else                                 w_nidx = bus.sel;
    end else if (r_tick) begin
      w_nidx = (r_ch == LAST) ? '0 : r_ch + SEL_W'(1);
    end
    w_change = (w_nidx != r_ch);
    w_blank  = bus.blank[w_nidx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_tick  <= 1'b0;
      r_ch    <= '0;
      r_guard <= '0;
      r_y     <= '0;
      r_an_n  <= ALL_OFF;
    end else begin
      r_pcnt <= (r_pcnt == PW'(DIV - 1)) ? '0 : r_pcnt + PW'(1);
      r_tick <= (r_pcnt == PW'(DIV - 1));
      r_ch   <= w_nidx;
      r_y    <= w_blank ? '0 : w_ch_data[w_nidx];
      // y follows the new channel immediately; only the enables wait out the guard.
      if (w_change) begin
        r_guard <= GW'(GUARD);
        r_an_n  <= ALL_OFF;
      end else if (r_guard != '0) begin
        r_guard <= r_guard - GW'(1);
        r_an_n  <= ALL_OFF;
      end else begin
        r_an_n  <= w_blank ? ALL_OFF : ~(NUM_CH'(1) << w_nidx);
      end
    end
  end

  assign bus.y      = r_y;
  assign bus.an_n   = r_an_n;
  assign bus.ch_idx = r_ch;
  assign bus.tick   = r_tick;
endmodule

// File: tb/tb_scan_mux_ctrl.sv
// Bench for scan_mux_ctrl: three builds (4ch/guard1, 3ch/guard3, 4ch/guard0) share one
// directed stimulus stream; each has a cycle-counting model plus literal spot checks.
module tb_scan_mux_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  blank;
  logic        mode;
  logic [1:0]  sel;

  int n_vec  = 0;
  int n_miss = 0;
  int kc     = 0;
  int n_tick = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", nm, kc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NC = (g == 1) ? 3 : 4;
    localparam int G  = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    localparam int SW = $clog2(NC);

    scan_mux_if #(.NUM_CH(NC), .DATA_W(4), .SEL_W(SW)) bus ();

    assign bus.data_in = data_in[NC*4-1:0];
    assign bus.blank   = blank[NC-1:0];
    assign bus.mode    = mode;
    assign bus.sel     = sel[SW-1:0];

    scan_mux_ctrl #(.NUM_CH(NC), .DATA_W(4), .DIV(DIV), .GUARD(G), .SEL_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Model: channel as an int, guard as "cycles since the last change", tick from an edge count.
    int          m_ch, m_since, m_cnt;
    logic [NC-1:0] exp_an;
    logic [3:0]  exp_y;
    logic        exp_tick;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
      int nidx;
      logic [15:0] sh;
      if (reset) begin
        m_ch = 0; m_since = 1000; m_cnt = 0;
        exp_tick = 1'b0; exp_y = 4'd0; exp_an = '1; m_valid = 1'b1;
      end else begin
        if (mode) nidx = (int'(sel) > NC - 1) ? NC - 1 : int'(sel);
        else      nidx = exp_tick ? (m_ch + 1) % NC : m_ch;
        if (nidx != m_ch)     m_since = 0;
        else if (m_since < 1000) m_since = m_since + 1;
        sh = data_in >> (4 * nidx);
        exp_y = blank[nidx] ? 4'd0 : sh[3:0];
        exp_an = '1;
        if (m_since > G && !blank[nidx]) exp_an[nidx] = 1'b0;
        m_cnt = m_cnt + 1;
        exp_tick = (m_cnt % DIV == 0);
        m_ch = nidx;
      end
    end

    always @(negedge clk) begin
      if (m_valid) begin
        chk($sformatf("cfg%0d y", g),      int'(bus.y),      int'(exp_y));
        chk($sformatf("cfg%0d an_n", g),   int'(bus.an_n),   int'(exp_an));
        chk($sformatf("cfg%0d ch_idx", g), int'(bus.ch_idx), m_ch);
        chk($sformatf("cfg%0d tick", g),   int'(bus.tick),   int'(exp_tick));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    kc++;
  endtask

  initial begin
    reset = 1'b1; data_in = 16'h4321; blank = 4'b0000; mode = 1'b0; sel = 2'd0;

    repeat (3) begin
      step();
      chk("rst an_n", int'(cfg[0].bus.an_n), 4'b1111);
      chk("rst y",    int'(cfg[0].bus.y),    0);
      chk("rst ch",   int'(cfg[0].bus.ch_idx), 0);
    end
    reset = 1'b0;
    kc = 0;

    // Auto scan, then blank channel 2 from step 20 on.
    for (int i = 0; i < 31; i++) begin
      step();
      if (kc <= 20) n_tick += int'(cfg[0].bus.tick);
      case (kc)
        1:  begin chk("pwr an_n", int'(cfg[0].bus.an_n), 4'b1110);
                  chk("pwr y", int'(cfg[0].bus.y), 1); end
        4:  chk("tick 4", int'(cfg[0].bus.tick), 1);
        5:  begin chk("step1 ch", int'(cfg[0].bus.ch_idx), 1);
                  chk("step1 y", int'(cfg[0].bus.y), 2);
                  chk("step1 guard", int'(cfg[0].bus.an_n), 4'b1111);
                  chk("tick 5", int'(cfg[0].bus.tick), 0); end
        6:  chk("step1 guard2", int'(cfg[0].bus.an_n), 4'b1111);
        7:  chk("step1 an_n", int'(cfg[0].bus.an_n), 4'b1101);
        13: begin chk("step3 ch", int'(cfg[0].bus.ch_idx), 3);
                  chk("step3 y", int'(cfg[0].bus.y), 4); end
        15: chk("step3 an_n", int'(cfg[0].bus.an_n), 4'b0111);
        17: begin chk("wrap ch", int'(cfg[0].bus.ch_idx), 0);
                  chk("wrap y", int'(cfg[0].bus.y), 1); end
        19: chk("wrap an_n", int'(cfg[0].bus.an_n), 4'b1110);
        23: chk("blank other an_n", int'(cfg[0].bus.an_n), 4'b1101);
        25: begin chk("blank ch", int'(cfg[0].bus.ch_idx), 2);
                  chk("blank y", int'(cfg[0].bus.y), 0); end
        27: begin chk("blank an_n", int'(cfg[0].bus.an_n), 4'b1111);
                  chk("blank y2", int'(cfg[0].bus.y), 0); end
        29: chk("after blank y", int'(cfg[0].bus.y), 4);
        31: chk("after blank an_n", int'(cfg[0].bus.an_n), 4'b0111);
        default: ;
      endcase
      if (kc == 20) blank = 4'b0100;
    end
    chk("tick count", n_tick, 5);

    // Manual select and clamp.
    blank = 4'b0000; mode = 1'b1; sel = 2'd2;
    step();
    chk("man ch", int'(cfg[0].bus.ch_idx), 2);
    chk("man y", int'(cfg[0].bus.y), 3);
    step();
    step();
    chk("man an_n", int'(cfg[0].bus.an_n), 4'b1011);
    step();
    chk("nc3 guard3", int'(cfg[1].bus.an_n), 3'b111);
    step();
    chk("nc3 an_n", int'(cfg[1].bus.an_n), 3'b011);
    sel = 2'd3;
    step();
    chk("clamp ch", int'(cfg[1].bus.ch_idx), 2);
    chk("clamp an_n", int'(cfg[1].bus.an_n), 3'b011);
    chk("sel3 an_n", int'(cfg[0].bus.an_n), 4'b1111);

    // Settle on channel 0, change data on the selected channel.
    sel = 2'd0;
    repeat (3) step();
    data_in = 16'h8765;
    step();
    chk("data follow y", int'(cfg[0].bus.y), 5);
    step();

    // Guard reload: 0 -> 1 -> 0 on consecutive cycles.
    sel = 2'd1;
    step();
    sel = 2'd0;
    step();
    chk("g0 change an_n", int'(cfg[2].bus.an_n), 4'b1111);
    step();
    chk("g0 an_n", int'(cfg[2].bus.an_n), 4'b1110);
    step();
    step();
    chk("g3 reload hold", int'(cfg[1].bus.an_n), 3'b111);
    step();
    chk("g3 reload an_n", int'(cfg[1].bus.an_n), 3'b110);

    // Reset during the guard after a change to channel 3.
    sel = 2'd3;
    step();
    chk("pre-rst ch", int'(cfg[0].bus.ch_idx), 3);
    chk("pre-rst an_n", int'(cfg[0].bus.an_n), 4'b1111);
    reset = 1'b1;
    step();
    chk("midrst ch", int'(cfg[0].bus.ch_idx), 0);
    chk("midrst an_n", int'(cfg[0].bus.an_n), 4'b1111);
    chk("midrst y", int'(cfg[0].bus.y), 0);
    chk("midrst tick", int'(cfg[0].bus.tick), 0);
    reset = 1'b0; mode = 1'b0; sel = 2'd0;
    step();
    chk("guard cleared an_n", int'(cfg[0].bus.an_n), 4'b1110);
    chk("guard cleared y", int'(cfg[0].bus.y), 5);

    // All channels blanked: scanning continues, nothing enabled.
    blank = 4'b1111;
    repeat (10) step();
    chk("allblank an_n", int'(cfg[0].bus.an_n), 4'b1111);
    chk("allblank y", int'(cfg[0].bus.y), 0);
    chk("allblank ch", int'(cfg[0].bus.ch_idx), 2);

    // Manual -> auto resume from the held channel.
    blank = 4'b0000; mode = 1'b1; sel = 2'd1;
    repeat (4) step();
    mode = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
